// File: rtl/neuron_mac_arb.sv
// neuron_mac_arb: round-robin arbiter sharing one neuron MAC among NUM_REQ requesters, one operation in flight.
module neuron_mac_arb #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_INPUTS = 8,
  parameter int X_W        = 8,
  parameter int W_W        = 8,
  parameter int B_W        = 32,
  parameter int OUT_W      = 16,
  localparam int ID_W      = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*B_W-1:0]             req_bias,
  input  logic [NUM_REQ*NUM_INPUTS*X_W-1:0]  req_x,
  input  logic [NUM_REQ*NUM_INPUTS*W_W-1:0]  req_w,
  input  logic [NUM_REQ*2-1:0]               req_act,
  input  logic [NUM_REQ*NUM_INPUTS-1:0]      req_mask,
  output logic                               mac_in_valid,
  input  logic                               mac_in_ready,
  output logic [B_W-1:0]                     mac_bias,
  output logic [NUM_INPUTS*X_W-1:0]          mac_x,
  output logic [NUM_INPUTS*W_W-1:0]          mac_w,
  output logic [1:0]                         mac_act,
  output logic [NUM_INPUTS-1:0]              mac_mask,
  input  logic                               mac_out_valid,
  output logic                               mac_out_ready,
  input  logic signed [OUT_W-1:0]            mac_out_data,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic signed [OUT_W-1:0]            rsp_data,
  output logic [ID_W-1:0]                    grant_id,
  output logic                               busy,
  output logic [15:0]                        op_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [ID_W-1:0] last_grant, winner;
  logic any;
  // Scan from farthest to nearest so the nearest valid requester after last_grant wins.
  always_comb begin
    winner = last_grant;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        winner = ID_W'((int'(last_grant) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end
  assign req_ready     = (state == IDLE && any && !rst) ? NUM_REQ'(1) << winner : '0;
  assign mac_in_valid  = state == ISSUE;
  assign mac_out_ready = state == WAIT;
  assign rsp_valid     = state == RESP ? NUM_REQ'(1) << grant_id : '0;
  assign busy          = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      mac_bias   <= '0;
      mac_x      <= '0;
      mac_w      <= '0;
      mac_act    <= '0;
      mac_mask   <= '0;
      rsp_data   <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          mac_bias   <= req_bias[winner*B_W +: B_W];
          mac_x      <= req_x[winner*NUM_INPUTS*X_W +: NUM_INPUTS*X_W];
          mac_w      <= req_w[winner*NUM_INPUTS*W_W +: NUM_INPUTS*W_W];
          mac_act    <= req_act[winner*2 +: 2];
          mac_mask   <= req_mask[winner*NUM_INPUTS +: NUM_INPUTS];
          grant_id   <= winner;
          last_grant <= winner;
          state      <= ISSUE;
        end
        ISSUE: if (mac_in_ready) state <= WAIT;
        WAIT: if (mac_out_valid) begin
          rsp_data <= mac_out_data;
          state    <= RESP;
        end
        default: if (rsp_ready[grant_id]) begin
          op_count <= op_count + 16'd1;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac_arb.sv
// tb_neuron_mac_arb: directed vectors and hand-written sequences for neuron_mac_arb.
module tb_neuron_mac_arb;
  logic clk = 0, rst = 1;
  logic [3:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [127:0] req_bias = '0;
  logic [255:0] req_x = '0, req_w = '0;
  logic [7:0] req_act = '0;
  logic [31:0] req_mask = '0, mac_bias;
  logic mac_in_valid, mac_in_ready = 0, mac_out_valid = 0, mac_out_ready, busy;
  logic [63:0] mac_x, mac_w;
  logic [1:0] mac_act, grant_id;
  logic [7:0] mac_mask;
  logic [15:0] mac_out_data = '0, rsp_data, op_count;
  int total = 0, bad = 0, exp_cnt = 0;

  neuron_mac_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_bias(req_bias), .req_x(req_x), .req_w(req_w), .req_act(req_act), .req_mask(req_mask),
    .mac_in_valid(mac_in_valid), .mac_in_ready(mac_in_ready), .mac_bias(mac_bias),
    .mac_x(mac_x), .mac_w(mac_w), .mac_act(mac_act), .mac_mask(mac_mask),
    .mac_out_valid(mac_out_valid), .mac_out_ready(mac_out_ready), .mac_out_data(mac_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .grant_id(grant_id), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full operation; vm/va = req_valid before/after the handshake, ro = extra rsp_ready bits.
  task automatic run_op(input logic [3:0] vm, va, input int id, input logic [31:0] b,
                        input logic [7:0] xb, wb, input logic [1:0] act, input logic [7:0] mk,
                        input logic [15:0] res, input int is, rs, input logic [3:0] ro);
    logic [3:0] oh;
    oh = 4'(1) << id;
    req_bias[id*32 +: 32] = b;
    req_x[id*64 +: 64] = {8{xb}};
    req_w[id*64 +: 64] = {8{wb}};
    req_act[id*2 +: 2] = act;
    req_mask[id*8 +: 8] = mk;
    req_valid = vm;
    #1 chk("req_ready_idle", req_ready, oh);
    @(negedge clk);
    req_valid = va;
    chk("busy_issue", busy, 1);
    chk("grant_id", grant_id, id);
    chk("mac_in_valid", mac_in_valid, 1);
    chk("mac_bias", mac_bias, b);
    chk("mac_x", mac_x, {8{xb}});
    chk("mac_w", mac_w, {8{wb}});
    chk("mac_act", mac_act, act);
    chk("mac_mask", mac_mask, mk);
    chk("req_ready_issue", req_ready, 0);
    mac_in_ready = 0;
    for (int i = 0; i < is; i++) begin
      @(negedge clk);
      chk("stall_in_valid", mac_in_valid, 1);
      chk("stall_mac_x", mac_x, {8{xb}});
      chk("stall_mac_bias", mac_bias, b);
      chk("stall_req_ready", req_ready, 0);
    end
    mac_in_ready = 1;
    @(negedge clk);
    mac_in_ready = 0;
    chk("wait_in_valid", mac_in_valid, 0);
    chk("wait_out_ready", mac_out_ready, 1);
    chk("wait_rsp_valid", rsp_valid, 0);
    mac_out_valid = 1;
    mac_out_data = res;
    @(negedge clk);
    mac_out_valid = 0;
    mac_out_data = ~res;
    chk("resp_out_ready", mac_out_ready, 0);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_data", rsp_data, res);
    chk("resp_op_count", op_count, exp_cnt);
    chk("resp_mac_w", mac_w, {8{wb}});
    rsp_ready = ro & ~oh;
    for (int i = 0; i < rs; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, oh);
      chk("hold_rsp_data", rsp_data, res);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_op_count", op_count, exp_cnt);
    end
    rsp_ready = ro | oh;
    @(negedge clk);
    rsp_ready = 0;
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    chk("done_op_count", op_count, exp_cnt);
    chk("done_busy", busy, 0);
    chk("done_rsp_valid", rsp_valid, 0);
  endtask

  typedef struct {
    int id;
    logic [31:0] b;
    logic [7:0] xb, wb;
    logic [1:0] act;
    logic [7:0] mk;
    logic [15:0] res;
    int is, rs;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{2, 32'h0000_0000, 8'h10, 8'h10, 2'd0, 8'hFF, 16'h0800, 0, 0};
    vecs[1] = '{0, 32'hFFFF_FF00, 8'h7F, 8'h81, 2'd1, 8'h0F, 16'h8001, 0, 0};
    vecs[2] = '{3, 32'h1234_5678, 8'hA5, 8'h5A, 2'd2, 8'hAA, 16'h7FFF, 1, 1};
    vecs[3] = '{1, 32'h8000_0000, 8'h01, 8'hFF, 2'd3, 8'h01, 16'hFFFF, 0, 0};
    vecs[4] = '{1, 32'hDEAD_BEEF, 8'h3C, 8'hC3, 2'd1, 8'hF0, 16'h0000, 3, 5};
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_valid", mac_in_valid, 0);
    chk("rst_out_ready", mac_out_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_mac_x", mac_x, 0);
    chk("rst_mac_bias", mac_bias, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 0;
    req_valid = 0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    for (int v = 0; v < 5; v++)
      run_op(4'(1) << vecs[v].id, 4'h0, vecs[v].id, vecs[v].b, vecs[v].xb, vecs[v].wb,
             vecs[v].act, vecs[v].mk, vecs[v].res, vecs[v].is, vecs[v].rs, 4'h0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
    for (int n = 0; n < 6; n++)
      run_op(4'hF, n == 5 ? 4'h0 : 4'hF, n % 4, 32'(n) * 32'h0101_0101, 8'(8'h20 + n),
             8'(8'h40 + n), 2'(n), 8'(8'h11 << (n % 4)), 16'(16'h1000 + n), 0, 0, 4'hF);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 0;
    chk("abort_grant", grant_id, 2);
    mac_in_ready = 1;
    @(negedge clk);
    mac_in_ready = 0;
    chk("abort_in_wait", mac_out_ready, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
    chk("abort_busy", busy, 0);
    chk("abort_in_valid", mac_in_valid, 0);
    chk("abort_out_ready", mac_out_ready, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_req_ready", req_ready, 0);
    chk("abort_op_count", op_count, 0);
    chk("abort_grant_id", grant_id, 0);
    mac_out_valid = 1;
    mac_out_data = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    mac_out_valid = 0;
    run_op(4'hF, 4'h0, 0, 32'h0000_0042, 8'h02, 8'h03, 2'd0, 8'hFF, 16'h0030, 0, 0, 4'h0);
    run_op(4'b1000, 4'b0010, 3, 32'h0000_0007, 8'h09, 8'h0A, 2'd2, 8'h3C, 16'hC000, 0, 2, 4'b0010);
    run_op(4'b0010, 4'h0, 1, 32'h0000_0001, 8'h05, 8'h06, 2'd1, 8'h81, 16'h0555, 0, 0, 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
